ball_motion: RTL and testbench

- Owns the ball position and velocity for the pong playfield.
- Drives XCord/YCord into the ball collision stage and consumes that stage's 3-bit ColOut code to reflect, speed up, or end the rally.
- Updates once per video frame: serve delay, motion, miss handling.

---
 rtl/ball_motion.sv | 188 ++++++++++++++++++
 tb/tb_ball_motion.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - pong ball position/velocity owner, updated once per frame
module ball_motion #(
  parameter int unsigned SERVE_X      = 320,
  parameter int unsigned SERVE_Y      = 240,
  parameter int unsigned SPEED_INIT   = 2,
  parameter int unsigned SPEED_MAX    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned Y_MIN        = 60,
  parameter int unsigned Y_MAX        = 420,
  parameter int unsigned X_MAX        = 639
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       FrameTick,
  input  logic       Pause,
  input  logic [2:0] ColOut,
  output logic [9:0] XCord,
  output logic [9:0] YCord,
  output logic       XDir,
  output logic       YDir,
  output logic [2:0] Speed,
  output logic       Serving,
  output logic       MissPulse,
  output logic [3:0] MissCount
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST    = CW'(SERVE_FRAMES - 1);
  localparam logic [9:0]    SERVE_X_W   = 10'(SERVE_X);
  localparam logic [9:0]    SERVE_Y_W   = 10'(SERVE_Y);
  localparam logic [2:0]    SPEED_INIT_W = 3'(SPEED_INIT);
  localparam logic [2:0]    SPEED_MAX_W = 3'(SPEED_MAX);
  localparam logic [10:0]   X_MAX_W     = 11'(X_MAX);
  localparam logic [10:0]   Y_MIN_W     = 11'(Y_MIN);
  localparam logic [10:0]   Y_MAX_W     = 11'(Y_MAX);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_MOVE  = 2'd1,
    ST_MISS  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            xdir_q, xdir_d;
  logic            ydir_q, ydir_d;
  logic [2:0]      speed_q, speed_d;
  logic            serving_q, serving_d;
  logic            miss_pulse_q, miss_pulse_d;
  logic [3:0]      miss_cnt_q, miss_cnt_d;

  // 11-bit working values so a step past either edge is seen before truncation
  logic [10:0]     x_ext, y_ext, sp_ext, x_sum, y_sum;
  logic            tick;

  assign tick = FrameTick && !Pause;

  // Next-state: serve countdown, collision response + step, miss reload
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    xdir_d       = xdir_q;
    ydir_d       = ydir_q;
    speed_d      = speed_q;
    miss_cnt_d   = miss_cnt_q;
    miss_pulse_d = 1'b0;
    x_ext        = {1'b0, x_q};
    y_ext        = {1'b0, y_q};
    sp_ext       = '0;
    x_sum        = '0;
    y_sum        = '0;

    if (tick) begin
      case (state_q)
        ST_SERVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_MOVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_MOVE: begin
          case (ColOut)
            3'd1: ydir_d = 1'b1;
            3'd2: ydir_d = 1'b0;
            3'd3: xdir_d = 1'b1;
            3'd4: begin
              xdir_d = 1'b0;
              if (speed_q < SPEED_MAX_W) speed_d = speed_q + 3'd1;
            end
            3'd5: state_d = ST_MISS;
            default: ;
          endcase

          // A miss freezes the ball where it is until the reload tick
          if (ColOut != 3'd5) begin
            sp_ext = {8'd0, speed_d};
            x_sum  = x_ext + sp_ext;
            y_sum  = y_ext + sp_ext;

            if (xdir_d) begin
              x_d = (x_sum > X_MAX_W) ? X_MAX_W[9:0] : x_sum[9:0];
            end else begin
              x_d = (x_ext < sp_ext) ? 10'd0 : x_q - {7'd0, speed_d};
            end

            // Hitting the floor/ceiling clamp also reflects, whatever ColOut said
            if (ydir_d) begin
              if (y_sum >= Y_MAX_W) begin
                y_d    = Y_MAX_W[9:0];
                ydir_d = 1'b0;
              end else begin
                y_d = y_sum[9:0];
              end
            end else begin
              if (y_ext <= Y_MIN_W + sp_ext) begin
                y_d    = Y_MIN_W[9:0];
                ydir_d = 1'b1;
              end else begin
                y_d = y_q - {7'd0, speed_d};
              end
            end
          end
        end

        ST_MISS: begin
          miss_pulse_d = 1'b1;
          if (miss_cnt_q != 4'hF) miss_cnt_d = miss_cnt_q + 4'd1;
          x_d     = SERVE_X_W;
          y_d     = SERVE_Y_W;
          speed_d = SPEED_INIT_W;
          xdir_d  = ~xdir_q;
          ydir_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end

        default: state_d = ST_SERVE;
      endcase
    end

    serving_d = (state_d == ST_SERVE);
  end

  // State register with synchronous active-low reset to the serve position
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= ST_SERVE;
      cnt_q        <= '0;
      x_q          <= SERVE_X_W;
      y_q          <= SERVE_Y_W;
      xdir_q       <= 1'b1;
      ydir_q       <= 1'b1;
      speed_q      <= SPEED_INIT_W;
      serving_q    <= 1'b1;
      miss_pulse_q <= 1'b0;
      miss_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xdir_q       <= xdir_d;
      ydir_q       <= ydir_d;
      speed_q      <= speed_d;
      serving_q    <= serving_d;
      miss_pulse_q <= miss_pulse_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign XCord     = x_q;
  assign YCord     = y_q;
  assign XDir      = xdir_q;
  assign YDir      = ydir_q;
  assign Speed     = speed_q;
  assign Serving   = serving_q;
  assign MissPulse = miss_pulse_q;
  assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - scoreboard bench for ball_motion
module tb_ball_motion;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       FrameTick = 1'b0;
  logic       Pause = 1'b0;
  logic [2:0] ColOut = 3'd0;
  logic [9:0] XCord, YCord;
  logic       XDir, YDir, Serving, MissPulse;
  logic [2:0] Speed;
  logic [3:0] MissCount;

  ball_motion dut (
    .Clk(Clk), .Rst(Rst), .FrameTick(FrameTick), .Pause(Pause), .ColOut(ColOut),
    .XCord(XCord), .YCord(YCord), .XDir(XDir), .YDir(YDir), .Speed(Speed),
    .Serving(Serving), .MissPulse(MissPulse), .MissCount(MissCount)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [30:0] exp_q[$];

  // Reference model of the ball (0 serve, 1 move, 2 miss)
  int m_st, m_cnt, m_x, m_y, m_xd, m_yd, m_sp, m_mp, m_mc;

  function automatic logic [30:0] dut_word();
    return {XCord, YCord, XDir, YDir, Speed, Serving, MissPulse, MissCount};
  endfunction

  function automatic logic [30:0] model_word();
    return {10'(m_x), 10'(m_y), 1'(m_xd), 1'(m_yd), 3'(m_sp),
            1'(m_st == 0), 1'(m_mp), 4'(m_mc)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_x = 320; m_y = 240; m_xd = 1; m_yd = 1;
    m_sp = 2; m_mp = 0; m_mc = 0;
  endtask

  task automatic model_tick(input int col);
    m_mp = 0;
    case (m_st)
      0: begin
        if (m_cnt == 59) begin m_cnt = 0; m_st = 1; end
        else m_cnt++;
      end
      1: begin
        case (col)
          1: m_yd = 1;
          2: m_yd = 0;
          3: m_xd = 1;
          4: begin m_xd = 0; if (m_sp < 7) m_sp++; end
          5: m_st = 2;
          default: ;
        endcase
        if (col != 5) begin
          if (m_xd != 0) m_x = (m_x + m_sp > 639) ? 639 : m_x + m_sp;
          else           m_x = (m_x < m_sp) ? 0 : m_x - m_sp;
          if (m_yd != 0) begin
            if (m_y + m_sp >= 420) begin m_y = 420; m_yd = 0; end
            else m_y = m_y + m_sp;
          end else begin
            if (m_y <= 60 + m_sp) begin m_y = 60; m_yd = 1; end
            else m_y = m_y - m_sp;
          end
        end
      end
      default: begin
        m_mp = 1;
        if (m_mc < 15) m_mc++;
        m_x = 320; m_y = 240; m_sp = 2; m_xd = (m_xd != 0) ? 0 : 1; m_yd = 1;
        m_cnt = 0; m_st = 0;
      end
    endcase
  endtask

  // Drive one FrameTick cycle and push the model's expectation for the next edge
  task automatic drive_tick(input logic [2:0] col, input logic pz);
    @(negedge Clk);
    FrameTick = 1'b1; ColOut = col; Pause = pz;
    if (pz) m_mp = 0;
    else model_tick(int'(col));
    exp_q.push_back(model_word());
    @(posedge Clk); #1;
    FrameTick = 1'b0; Pause = 1'b0; ColOut = 3'd0;
  endtask

  task automatic test_reset();
    logic [30:0] got, expw;
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    exp_q.push_back(model_word());
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL reset_state got=%h exp=%h", got, expw); n_err++; end
    n_cmp++;
    if (got !== {10'd320, 10'd240, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 4'd0}) begin
      $display("FAIL reset_const got=%h", got); n_err++;
    end
    @(negedge Clk); Rst = 1'b1;
  endtask

  task automatic test_serve(input logic rand_col);
    logic [30:0] got, expw;
    logic [2:0] c;
    for (int i = 0; i < 60; i++) begin
      c = rand_col ? 3'($urandom_range(0, 7)) : 3'd0;
      drive_tick(c, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL serve_tick%0d got=%h exp=%h", i, got, expw); n_err++; end
      if (i == 58) begin
        n_cmp++;
        if (Serving !== 1'b1) begin $display("FAIL serve_hold got=%b exp=1", Serving); n_err++; end
      end
    end
    n_cmp++;
    if (Serving !== 1'b0 || XCord !== 10'd320 || YCord !== 10'd240) begin
      $display("FAIL serve_launch got=%b/%0d/%0d exp=0/320/240", Serving, XCord, YCord); n_err++;
    end
  endtask

  task automatic test_move();
    logic [30:0] got, expw;
    logic [2:0] c;
    drive_tick(3'd0, 1'b0);
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL move_first got=%h exp=%h", got, expw); n_err++; end
    n_cmp++;
    if (XCord !== 10'd322 || YCord !== 10'd242) begin
      $display("FAIL move_step got=%0d/%0d exp=322/242", XCord, YCord); n_err++;
    end
    for (int i = 0; i < 12; i++) begin
      c = 3'($urandom_range(0, 7));
      if (c == 3'd5) c = 3'd0;
      drive_tick(c, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL move_rand%0d col=%0d got=%h exp=%h", i, c, got, expw); n_err++; end
    end
  endtask

  task automatic test_pause();
    logic [30:0] got, expw;
    for (int i = 0; i < 5; i++) begin
      drive_tick(3'(i % 6), 1'b1);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL pause%0d got=%h exp=%h", i, got, expw); n_err++; end
    end
  endtask

  task automatic test_ceiling();
    logic [30:0] got, expw;
    int k;
    drive_tick(3'd2, 1'b0);
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL ceil_floorhit got=%h exp=%h", got, expw); n_err++; end
    k = 0;
    while (m_y != 60 && k < 300) begin
      drive_tick(3'd0, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL ceil_walk%0d got=%h exp=%h", k, got, expw); n_err++; end
      k++;
    end
    n_cmp++;
    if (YCord !== 10'd60 || YDir !== 1'b1) begin
      $display("FAIL ceil_clamp got=%0d/%b exp=60/1", YCord, YDir); n_err++;
    end
  endtask

  task automatic test_wall();
    logic [30:0] got, expw;
    int k;
    drive_tick(3'd4, 1'b0);
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL wall_paddle got=%h exp=%h", got, expw); n_err++; end
    k = 0;
    while (m_x != 0 && k < 400) begin
      drive_tick(3'd0, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL wall_walk%0d got=%h exp=%h", k, got, expw); n_err++; end
      k++;
    end
    n_cmp++;
    if (XCord !== 10'd0) begin $display("FAIL wall_clamp got=%0d exp=0", XCord); n_err++; end
    drive_tick(3'd3, 1'b0);
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL wall_back got=%h exp=%h", got, expw); n_err++; end
    n_cmp++;
    if (XDir !== 1'b1 || XCord !== 10'(m_sp)) begin
      $display("FAIL wall_reflect got=%b/%0d exp=1/%0d", XDir, XCord, m_sp); n_err++;
    end
  endtask

  task automatic test_speed_sat();
    logic [30:0] got, expw;
    for (int i = 0; i < 8; i++) begin
      drive_tick(3'd4, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL speed_hit%0d got=%h exp=%h", i, got, expw); n_err++; end
    end
    n_cmp++;
    if (Speed !== 3'd7 || XDir !== 1'b0) begin
      $display("FAIL speed_sat got=%0d/%b exp=7/0", Speed, XDir); n_err++;
    end
  endtask

  task automatic test_miss();
    logic [30:0] got, expw;
    drive_tick(3'd5, 1'b0);
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL miss_enter got=%h exp=%h", got, expw); n_err++; end
    drive_tick(3'd0, 1'b0);
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL miss_reload got=%h exp=%h", got, expw); n_err++; end
    n_cmp++;
    if (MissPulse !== 1'b1 || MissCount !== 4'd1 || XCord !== 10'd320 || YCord !== 10'd240 ||
        Serving !== 1'b1 || XDir !== 1'b1 || Speed !== 3'd2) begin
      $display("FAIL miss_values got=%b/%0d/%0d/%0d/%b/%b/%0d exp=1/1/320/240/1/1/2",
               MissPulse, MissCount, XCord, YCord, Serving, XDir, Speed); n_err++;
    end
    @(negedge Clk);
    m_mp = 0;
    exp_q.push_back(model_word());
    @(posedge Clk); #1;
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL miss_pulse_drop got=%h exp=%h", got, expw); n_err++; end
  endtask

  task automatic test_reset_mid();
    logic [30:0] got, expw;
    test_serve(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_tick(3'd0, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL rmid_move%0d got=%h exp=%h", i, got, expw); n_err++; end
    end
    @(negedge Clk);
    Rst = 1'b0; FrameTick = 1'b1; ColOut = 3'd4;
    model_reset();
    exp_q.push_back(model_word());
    @(posedge Clk); #1;
    got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
    if (got !== expw) begin $display("FAIL rmid_reset got=%h exp=%h", got, expw); n_err++; end
    @(negedge Clk);
    Rst = 1'b1; FrameTick = 1'b0; ColOut = 3'd0;
  endtask

  task automatic test_back_to_back_miss();
    logic [30:0] got, expw;
    for (int k = 0; k < 16; k++) begin
      test_serve(1'b0);
      drive_tick(3'd5, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL b2b_enter%0d got=%h exp=%h", k, got, expw); n_err++; end
      drive_tick(3'd0, 1'b0);
      got = dut_word(); expw = exp_q.pop_front(); n_cmp++;
      if (got !== expw) begin $display("FAIL b2b_reload%0d got=%h exp=%h", k, got, expw); n_err++; end
    end
    n_cmp++;
    if (MissCount !== 4'd15) begin $display("FAIL miss_saturate got=%0d exp=15", MissCount); n_err++; end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve(1'b1);
    test_move();
    test_pause();
    test_ceiling();
    test_wall();
    test_speed_sat();
    test_miss();
    test_reset_mid();
    test_back_to_back_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
